mips_run_ctrl: RTL and testbench
================================

// Module: mips_run_ctrl
// PURPOSE
//  Parametrised clock-enable / reset sequencer for the multi-cycle MIPS core.
//  Sits between board clk/rst and the core: stretches and synchronises reset,
//  and gates the core clock enable by a programmable divider and a run mode
//  (halt / free-run / single-step), with a cycle counter and optional limit.
// PARAMETERS
//  RST_HOLD  4   core reset held this many clk cycles after sync'd release (>=1)
//  DIV_W     8   width of clock-enable divider value
//  CNT_W     32  width of core cycle counter and limit
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      asynchronous, active-low reset
//  mode       in   2      00 halt, 01 run, 10 step, 11 reserved (= halt)
//  step_req   in   1      step request; rising edge acts, level ignored
//  div        in   DIV_W  core_ce asserted once every div+1 clk cycles
//  halt_req   in   1      halt request from core (e.g. break instruction)
//  cyc_limit  in   CNT_W  stop after this many core_ce pulses; 0 = unlimited
//  core_rst   out  1      active-high reset to core (drives mips.rst)
//  core_ce    out  1      one-clk-wide core clock-enable pulse
//  halted     out  1      1 while in IDLE
//  done       out  1      1 while in DONE (limit reached)
//  cyc_cnt    out  CNT_W  count of core_ce pulses issued since reset
// BEHAVIOUR
//  Reset (rst=0, async): state=HOLD, core_rst=1, core_ce=0, halted=0, done=0,
//   cyc_cnt=0, divider count=0, sync flops=0, hold count=0, step edge reg=0.
//  rst release passes a 2-flop synchroniser; HOLD then counts RST_HOLD cycles.
//   core_rst falls on the (2+RST_HOLD)th rising edge after rst goes high; same
//   edge state -> IDLE. rst reasserted in any state/mid-step -> immediate reset.
//  Divider: free-running counter dc, runs outside HOLD. tick = (dc >= div);
//   tick -> dc=0 next cycle, else dc+1. '>=' makes a div decrease take effect
//   without wrap. div=0 -> tick every cycle.
//  States: HOLD, IDLE, RUN, STEP, DONE.
//   IDLE: halted=1. mode=01 -> RUN. mode=10 and step_req rising edge -> STEP.
//   RUN: core_ce=tick. halt_req=1 or mode!=01 -> IDLE next cycle; core_ce=0 in
//    that cycle (halt beats tick).
//   STEP: waits for next tick, issues exactly one core_ce, -> IDLE. Mode change
//    and halt_req ignored until the pulse is issued. step edges in STEP dropped.
//   DONE: core_ce=0, done=1. mode=00 -> IDLE (done clears, cyc_cnt kept).
//  cyc_cnt += 1 on every core_ce pulse; saturates at all-ones, never wraps.
//  Limit: when cyc_limit!=0 and a core_ce pulse makes cyc_cnt == cyc_limit,
//   next state = DONE (beats halt_req and mode change in same cycle).
//   cyc_limit <= current cyc_cnt written while running: no pulse is blocked;
//   DONE is entered only on equality, so counting continues to saturation.
//  core_ce is registered-free combinational from state and tick; all other
//   outputs registered. core_ce never high while core_rst=1.
// TESTING
//  rst low 3 cycles then high, RST_HOLD=4 -> core_rst falls exactly 6 edges
//   after release; core_ce=0, halted=1 from that edge.
//  mode=01, div=2 -> core_ce every 3rd cycle; after 30 cycles cyc_cnt=10.
//  mode=10, three step_req edges 10 cycles apart, div=3 -> exactly 3 core_ce
//   pulses, cyc_cnt=3, halted=1 between steps; held-high step_req gives 1 only.
//  mode=01, cyc_limit=5, div=0 -> 5 consecutive core_ce, done=1, cyc_cnt=5;
//   mode=00 -> done=0, halted=1, cyc_cnt stays 5.
//  RUN, halt_req=1 on a tick cycle -> no core_ce that cycle, halted=1 next.
//  rst=0 mid-STEP before tick -> core_rst=1, cyc_cnt=0 immediately, no pulse.

Source files
------------

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_run_ctrl
//  Brief    : Clock-enable / reset sequencer for the multi-cycle MIPS core.
//             Synchronises and stretches reset, then gates the core clock
//             enable by a programmable divider and a halt/run/step mode,
//             with a saturating cycle counter and optional cycle limit.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_run_ctrl #(
    parameter int RST_HOLD = 4,
    parameter int DIV_W    = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_req,
    input  logic [DIV_W-1:0] div,
    input  logic             halt_req,
    input  logic [CNT_W-1:0] cyc_limit,
    output logic             core_rst,
    output logic             core_ce,
    output logic             halted,
    output logic             done,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_IDLE = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_sync;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [DIV_W-1:0]  r_dc;
    logic              r_step_q;

    logic              w_tick;
    logic              w_step_edge;
    logic              w_mode_run;
    logic              w_mode_step;
    logic              w_hold_end;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_limit_hit;

    // '>=' rather than '==' so a lowered div takes effect without a wrap
    assign w_tick      = (r_dc >= div);
    assign w_step_edge = step_req & ~r_step_q;
    assign w_mode_run  = (mode == 2'b01);
    assign w_mode_step = (mode == 2'b10);
    assign w_hold_end  = r_sync[1] && (r_hold_cnt == c_hold_last);

    // Halt request and mode change suppress the pulse in RUN; STEP only waits for tick
    assign core_ce = ((r_state == S_RUN) && w_tick && w_mode_run && !halt_req) ||
                     ((r_state == S_STEP) && w_tick);

    assign w_cnt_inc   = (cyc_cnt == {CNT_W{1'b1}}) ? cyc_cnt : cyc_cnt + CNT_W'(1);
    assign w_limit_hit = core_ce && (cyc_limit != '0) && (w_cnt_inc == cyc_limit);

    // Two-flop synchroniser for the reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    // Stretch reset for RST_HOLD cycles once the synchronised release arrives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt <= '0;
        end else if ((r_state == S_HOLD) && r_sync[1] && !w_hold_end) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end

    // Free-running enable divider, frozen while the core is held in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dc <= '0;
        end else if (r_state != S_HOLD) begin
            r_dc <= w_tick ? '0 : r_dc + DIV_W'(1);
        end
    end

    // Previous step_req level for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step_req;
        end
    end

    // Saturating count of issued core_ce pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0;
        end else if (core_ce) begin
            cyc_cnt <= w_cnt_inc;
        end
    end

    // Next-state selection; reaching the limit overrides every other exit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HOLD: if (w_hold_end) w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (w_mode_run)
                    w_state_nxt = S_RUN;
                else if (w_mode_step && w_step_edge)
                    w_state_nxt = S_STEP;
            end
            S_RUN:  if (halt_req || !w_mode_run) w_state_nxt = S_IDLE;
            S_STEP: if (core_ce) w_state_nxt = S_IDLE;
            S_DONE: if (!w_mode_run && !w_mode_step) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_HOLD;
        endcase
        if (w_limit_hit) w_state_nxt = S_DONE;
    end

    // State register with status outputs registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_HOLD;
            core_rst <= 1'b1;
            halted   <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            core_rst <= (w_state_nxt == S_HOLD);
            halted   <= (w_state_nxt == S_IDLE);
            done     <= (w_state_nxt == S_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_run_ctrl
//  Brief    : Self-checking bench for mips_run_ctrl against a behavioural model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_run_ctrl;

    localparam int RST_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        step_req = 1'b0;
    logic [7:0]  div = 8'd0;
    logic        halt_req = 1'b0;
    logic [31:0] cyc_limit = 32'd0;
    logic        core_rst, core_ce, halted, done;
    logic [31:0] cyc_cnt;
    logic        s_core_rst, s_core_ce, s_halted, s_done;
    logic [2:0]  s_cyc_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mips_run_ctrl #(.RST_HOLD(RST_HOLD), .DIV_W(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mode(mode), .step_req(step_req), .div(div),
        .halt_req(halt_req), .cyc_limit(cyc_limit), .core_rst(core_rst),
        .core_ce(core_ce), .halted(halted), .done(done), .cyc_cnt(cyc_cnt)
    );

    // narrow-counter copy, only used to observe saturation
    mips_run_ctrl #(.RST_HOLD(RST_HOLD), .DIV_W(8), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .mode(mode), .step_req(step_req), .div(div),
        .halt_req(halt_req), .cyc_limit(3'd0), .core_rst(s_core_rst),
        .core_ce(s_core_ce), .halted(s_halted), .done(s_done), .cyc_cnt(s_cyc_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    localparam int M_HOLD = 0, M_IDLE = 1, M_RUN = 2, M_STEP = 3, M_DONE = 4;
    int          m_st;
    int          m_rel;
    int          m_dc;
    logic [31:0] m_cnt;
    bit          m_stepq;

    function automatic void model_reset();
        m_st = M_HOLD; m_rel = 0; m_dc = 0; m_cnt = 0; m_stepq = 0;
    endfunction

    function automatic bit m_tick();
        return m_dc >= int'(div);
    endfunction

    function automatic bit m_ce();
        if (m_st == M_RUN)  return m_tick() && mode == 2'b01 && !halt_req;
        if (m_st == M_STEP) return m_tick();
        return 0;
    endfunction

    function automatic void model_edge();
        bit ce;
        int nxt;
        if (!rst) begin
            model_reset();
            return;
        end
        ce = m_ce();
        if (m_st == M_HOLD) begin
            m_rel++;
            if (m_rel >= 2 + RST_HOLD) m_st = M_IDLE;
        end else begin
            nxt = m_st;
            case (m_st)
                M_IDLE: if (mode == 2'b01) nxt = M_RUN;
                        else if (mode == 2'b10 && step_req && !m_stepq) nxt = M_STEP;
                M_RUN:  if (halt_req || mode != 2'b01) nxt = M_IDLE;
                M_STEP: if (ce) nxt = M_IDLE;
                M_DONE: if (mode == 2'b00 || mode == 2'b11) nxt = M_IDLE;
                default: ;
            endcase
            if (ce) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (cyc_limit != 0 && m_cnt == cyc_limit) nxt = M_DONE;
            end
            m_dc = m_tick() ? 0 : m_dc + 1;
            m_st = nxt;
        end
        m_stepq = step_req;
    endfunction

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        mode = 2'b00; step_req = 0; halt_req = 0; cyc_limit = 0; div = 0;
        rst = 0; model_reset();
        repeat (2) advance();
        rst = 1;
        repeat (2 + RST_HOLD) advance();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 0; model_reset();
        repeat (3) advance();
        #1;
        n_checks++;
        if (core_rst !== 1'b1 || core_ce !== 1'b0 || halted !== 1'b0 || done !== 1'b0 || cyc_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rst=%0b ce=%0b halted=%0b done=%0b cnt=%0d want 1 0 0 0 0",
                     core_rst, core_ce, halted, done, cyc_cnt);
        end
        rst = 1;
        for (int e = 0; e < 9; e++) begin
            #1;
            n_checks++;
            if (core_rst !== (e < 2 + RST_HOLD) || halted !== (e >= 2 + RST_HOLD) || core_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release edge%0d: got core_rst=%0b halted=%0b ce=%0b want core_rst=%0b halted=%0b ce=0",
                         e, core_rst, halted, core_ce, e < 2 + RST_HOLD, e >= 2 + RST_HOLD);
            end
            advance();
        end
    endtask

    task automatic test_run_div();
        do_reset();
        mode = 2'b01; div = 8'd2;
        advance();
        for (int i = 0; i < 30; i++) begin
            #1;
            n_checks++;
            if (core_ce !== m_ce() || cyc_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL run_div cyc%0d: got ce=%0b cnt=%0d want ce=%0b cnt=%0d", i, core_ce, cyc_cnt, m_ce(), m_cnt);
            end
            advance();
        end
        #1;
        n_checks++;
        if (cyc_cnt !== 32'd10) begin
            n_fail++;
            $display("FAIL run_div_total: got cnt=%0d want 10", cyc_cnt);
        end
        mode = 2'b00;
        advance();
    endtask

    task automatic test_step();
        int pulses = 0;
        do_reset();
        mode = 2'b10; div = 8'd3;
        for (int k = 0; k < 3; k++) begin
            step_req = 1;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (core_ce) pulses++;
                n_checks++;
                if (core_ce !== m_ce()) begin
                    n_fail++;
                    $display("FAIL step_ce k%0d cyc%0d: got %0b want %0b", k, i, core_ce, m_ce());
                end
                advance();
                step_req = 0;
            end
            #1;
            n_checks++;
            if (halted !== 1'b1) begin
                n_fail++;
                $display("FAIL step_halted k%0d: got %0b want 1", k, halted);
            end
        end
        n_checks++;
        if (pulses != 3 || cyc_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL step_count: got pulses=%0d cnt=%0d want 3 3", pulses, cyc_cnt);
        end
        pulses = 0;
        step_req = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (core_ce) pulses++;
            advance();
        end
        step_req = 0;
        #1;
        n_checks++;
        if (pulses != 1 || cyc_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL step_held: got pulses=%0d cnt=%0d want 1 4", pulses, cyc_cnt);
        end
    endtask

    task automatic test_limit();
        do_reset();
        cyc_limit = 32'd5; div = 8'd0; mode = 2'b01;
        advance();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (core_ce !== 1'b1) begin
                n_fail++;
                $display("FAIL limit_ce cyc%0d: got %0b want 1", i, core_ce);
            end
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (done !== 1'b1 || core_ce !== 1'b0 || cyc_cnt !== 32'd5) begin
                n_fail++;
                $display("FAIL limit_done cyc%0d: got done=%0b ce=%0b cnt=%0d want 1 0 5", i, done, core_ce, cyc_cnt);
            end
            advance();
        end
        mode = 2'b00;
        advance();
        #1;
        n_checks++;
        if (done !== 1'b0 || halted !== 1'b1 || cyc_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL limit_exit: got done=%0b halted=%0b cnt=%0d want 0 1 5", done, halted, cyc_cnt);
        end
    endtask

    task automatic test_halt();
        bit found = 0;
        do_reset();
        mode = 2'b01; div = 8'd3;
        advance();
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_tick()) found = 1;
            else advance();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL halt_tick_timeout: got no tick want tick within 10");
        end
        halt_req = 1;
        #1;
        n_checks++;
        if (core_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_ce: got %0b want 0", core_ce);
        end
        advance();
        halt_req = 0; mode = 2'b00;
        #1;
        n_checks++;
        if (halted !== 1'b1 || cyc_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL halt_idle: got halted=%0b cnt=%0d want 1 %0d", halted, cyc_cnt, m_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 2'b01; div = 8'd0;
        repeat (5) advance();
        mode = 2'b00; advance();
        mode = 2'b10; div = 8'd200; step_req = 1;
        advance();
        step_req = 0;
        repeat (3) advance();
        #1;
        n_checks++;
        if (halted !== 1'b0 || core_ce !== 1'b0 || cyc_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL async_pre: got halted=%0b ce=%0b cnt=%0d want 0 0 4", halted, core_ce, cyc_cnt);
        end
        #2;
        rst = 0; model_reset();
        #1;
        n_checks++;
        if (core_rst !== 1'b1 || cyc_cnt !== 32'd0 || core_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got core_rst=%0b cnt=%0d ce=%0b want 1 0 0", core_rst, cyc_cnt, core_ce);
        end
        @(negedge clk);
        advance();
        rst = 1;
        repeat (2 + RST_HOLD) advance();
    endtask

    task automatic test_saturation();
        do_reset();
        mode = 2'b01; div = 8'd0;
        advance();
        for (int i = 0; i < 12; i++) begin
            #1;
            n_checks++;
            if (s_cyc_cnt !== ((m_cnt > 7) ? 3'd7 : m_cnt[2:0])) begin
                n_fail++;
                $display("FAIL saturation cyc%0d: got %0d want %0d", i, s_cyc_cnt, (m_cnt > 7) ? 7 : m_cnt);
            end
            advance();
        end
        #1;
        n_checks++;
        if (s_cyc_cnt !== 3'd7 || cyc_cnt !== 32'd12) begin
            n_fail++;
            $display("FAIL saturation_end: got small=%0d wide=%0d want 7 12", s_cyc_cnt, cyc_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) div = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) step_req = ~step_req;
            halt_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0)
                cyc_limit = ($urandom_range(0, 1) == 0) ? 32'd0 : m_cnt + 32'($urandom_range(0, 6));
            if ($urandom_range(0, 399) == 0) begin
                rst = 0; model_reset();
            end else if (!rst && $urandom_range(0, 1) == 0) begin
                rst = 1;
            end
            #1;
            n_checks++;
            if (core_ce !== m_ce() || core_rst !== (m_st == M_HOLD) || halted !== (m_st == M_IDLE) ||
                done !== (m_st == M_DONE) || cyc_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL random cyc%0d: got ce=%0b rst=%0b halted=%0b done=%0b cnt=%0d want ce=%0b rst=%0b halted=%0b done=%0b cnt=%0d",
                         i, core_ce, core_rst, halted, done, cyc_cnt,
                         m_ce(), m_st == M_HOLD, m_st == M_IDLE, m_st == M_DONE, m_cnt);
            end
            advance();
        end
        rst = 1;
    endtask

    initial begin
        model_reset();
        #1 rst = 0;
        @(negedge clk);
        test_reset();
        test_run_div();
        test_step();
        test_limit();
        test_halt();
        test_async_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
